tlul_arb_rr_m1: RTL and testbench

- M-host to 1-device TL-UL arbiter with fair round-robin grant and in-order response routing.
- Sits in front of a shared device port (e.g. ICCM, FLASH_CTRL, timers) wherever several xbar host sockets converge on one device.
- Adds zero latency on the A channel.
- Tracks outstanding transactions in an ID FIFO so D-channel responses return to the issuing host.

---
 rtl/tlul_pkg.sv | 29 ++
 rtl/tlul_arb_idfifo.sv | 51 +++++
 rtl/tlul_arb_rr_m1.sv | 94 +++++++++
 tb/tb_tlul_arb_rr_m1.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel structs shared by the arbiter and its bench.
// Only the fields the arbiter routes are modelled.
package tlul_pkg;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/tlul_arb_idfifo.sv
// Response-routing FIFO: holds the host index of every accepted A beat
// until its D beat returns. Depth must be a power of two.
module tlul_arb_idfifo #(
   parameter int Depth = 4,
   parameter int Width = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push,
   input  logic [Width-1:0]         wdata,
   input  logic                     pop,
   output logic [Width-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   count
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr, rd_ptr;
   logic [CntW-1:0]  cnt;
   logic             do_push, do_pop;

   // full/empty come straight from the count register, so a pop cannot
   // free a slot for a push in the same cycle
   assign full    = (cnt == CntW'(Depth));
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/tlul_arb_rr_m1.sv
// M-host to 1-device TL-UL arbiter: zero-latency round-robin A grant with
// a hold lock, and in-order D routing back to the issuing host.
module tlul_arb_rr_m1
   import tlul_pkg::*;
#(
   parameter int M              = 3,
   parameter int MaxOutstanding = 4,
   parameter int IdW            = $clog2(M)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  tl_h2d_t [M-1:0]                 tl_h_i,
   output tl_d2h_t [M-1:0]                 tl_h_o,
   output tl_h2d_t                         tl_d_o,
   input  tl_d2h_t                         tl_d_i,
   output logic [$clog2(MaxOutstanding):0] outstanding_o,
   output logic                            err_spurious_o
);

   // first requester at or after ptr, wrapping; smallest offset wins
   function automatic logic [IdW-1:0] rr_find(input logic [M-1:0] req,
                                              input logic [IdW-1:0] ptr);
      logic [IdW-1:0] idx;
      rr_find = ptr;
      for (int k = M - 1; k >= 0; k--) begin
         idx = IdW'((int'(ptr) + k) % M);
         if (req[idx]) rr_find = idx;
      end
   endfunction

   logic [M-1:0]   req;
   logic [IdW-1:0] ptr_q, gnt_q, gnt, head;
   logic           lock_q, gnt_valid, host_valid, accept, pop;
   logic           fifo_full, fifo_empty;

   always_comb begin
      req = '0;
      for (int i = 0; i < M; i++) req[i] = tl_h_i[i].a_valid;
   end

   assign gnt        = lock_q ? gnt_q : rr_find(req, ptr_q);
   assign gnt_valid  = lock_q | (|req);
   assign host_valid = gnt_valid & tl_h_i[gnt].a_valid & rst_ni;

   // empty FIFO: any device response is spurious and gets sunk here
   always_comb begin
      tl_d_o         = tl_h_i[gnt];
      tl_d_o.a_valid = host_valid & ~fifo_full;
      tl_d_o.d_ready = fifo_empty ? tl_d_i.d_valid : tl_h_i[head].d_ready;
   end

   assign accept = tl_d_o.a_valid & tl_d_i.a_ready;
   assign pop    = tl_d_i.d_valid & tl_d_o.d_ready & ~fifo_empty;

   always_comb begin
      for (int i = 0; i < M; i++) begin
         tl_h_o[i]         = tl_d_i;
         tl_h_o[i].d_valid = tl_d_i.d_valid & ~fifo_empty & (head == IdW'(i));
         tl_h_o[i].a_ready = gnt_valid & rst_ni & (gnt == IdW'(i)) &
                             tl_d_i.a_ready & ~fifo_full;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q          <= '0;
         gnt_q          <= '0;
         lock_q         <= 1'b0;
         err_spurious_o <= 1'b0;
      end else begin
         if (accept) ptr_q <= (gnt == IdW'(M - 1)) ? '0 : gnt + 1'b1;
         // an offered but unaccepted beat pins the grant until it lands
         lock_q <= host_valid & ~accept;
         if (host_valid & ~accept) gnt_q <= gnt;
         if (tl_d_i.d_valid & fifo_empty) err_spurious_o <= 1'b1;
      end
   end

   tlul_arb_idfifo #(
      .Depth (MaxOutstanding),
      .Width (IdW)
   ) u_idfifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (accept),
      .wdata  (gnt),
      .pop    (pop),
      .rdata  (head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (outstanding_o)
   );

endmodule

// File: tb/tb_tlul_arb_rr_m1.sv
// Bench for tlul_arb_rr_m1: directed scenarios plus a random phase, all
// checked every cycle against a queue-based reference model.
module tb_tlul_arb_rr_m1;
   import tlul_pkg::*;

   localparam int M    = 3;
   localparam int MAXO = 4;
   localparam int CW   = 3;

   logic            clk = 1'b0;
   logic            rst_ni = 1'b0;
   tl_h2d_t [M-1:0] h_i;
   tl_d2h_t [M-1:0] h_o;
   tl_h2d_t         d_o;
   tl_d2h_t         d_i;
   logic [CW-1:0]   outstanding;
   logic            err_sp;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_ptr, m_lock, m_lhost, m_g;
   int m_q[$];
   bit m_spur, m_gv, m_full, m_aval, m_dready;

   always #5 clk = ~clk;

   tlul_arb_rr_m1 #(.M(M), .MaxOutstanding(MAXO)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .tl_h_i         (h_i),
      .tl_h_o         (h_o),
      .tl_d_o         (d_o),
      .tl_d_i         (d_i),
      .outstanding_o  (outstanding),
      .err_spurious_o (err_sp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < M; i++) begin
         h_i[i] = '0;
         h_i[i].a_source = 8'(i);
      end
      d_i = '0;
   endtask

   task automatic m_reset();
      m_ptr = 0; m_lock = 0; m_lhost = 0; m_spur = 0;
      m_q.delete();
   endtask

   // expected outputs for the current inputs, compared at the negedge
   task automatic model_eval(input int exp_src);
      bit dv;
      m_full = (m_q.size() == MAXO);
      m_gv = 0; m_g = 0;
      if (m_lock != 0) begin
         m_g = m_lhost; m_gv = 1;
      end else begin
         for (int k = 0; k < M; k++) begin
            int idx = (m_ptr + k) % M;
            if (!m_gv && h_i[idx].a_valid) begin m_g = idx; m_gv = 1; end
         end
      end
      m_aval   = m_gv && h_i[m_g].a_valid && !m_full;
      m_dready = (m_q.size() > 0) ? h_i[m_q[0]].d_ready : d_i.d_valid;
      chk("dev_a_valid", d_o.a_valid, m_aval);
      if (m_aval) begin
         chk("dev_a_source", d_o.a_source, h_i[m_g].a_source);
         chk("dev_a_address", d_o.a_address, h_i[m_g].a_address);
      end
      if (exp_src >= 0) chk("grant_order", d_o.a_source, exp_src);
      chk("dev_d_ready", d_o.d_ready, m_dready);
      for (int i = 0; i < M; i++) begin
         chk($sformatf("h%0d_a_ready", i), h_o[i].a_ready,
             (m_gv && i == m_g) ? (d_i.a_ready && !m_full) : 1'b0);
         dv = (m_q.size() > 0) && (m_q[0] == i) && d_i.d_valid;
         chk($sformatf("h%0d_d_valid", i), h_o[i].d_valid, dv);
         if (dv) chk($sformatf("h%0d_d_data", i), h_o[i].d_data, d_i.d_data);
      end
      chk("outstanding", outstanding, m_q.size());
      chk("err_spurious", err_sp, m_spur);
   endtask

   task automatic model_update();
      bit acc, pp;
      acc = m_aval && d_i.a_ready;
      pp  = (m_q.size() > 0) && d_i.d_valid && m_dready;
      if (m_q.size() == 0 && d_i.d_valid) m_spur = 1;
      if (pp) void'(m_q.pop_front());
      if (acc) begin
         m_q.push_back(m_g);
         m_ptr = (m_g + 1) % M;
      end
      m_lock = (m_gv && h_i[m_g].a_valid && !acc) ? 1 : 0;
      if (m_lock != 0) m_lhost = m_g;
   endtask

   task automatic cyc(input int exp_src = -1);
      @(negedge clk);
      model_eval(exp_src);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk);
      rst_ni = 1'b0;
      #1;
      m_reset();
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err_sp, 0);
      chk("rst_dev_a_valid", d_o.a_valid, 0);
      chk("rst_dev_d_ready", d_o.d_ready, 0);
      for (int i = 0; i < M; i++) begin
         chk("rst_a_ready", h_o[i].a_ready, 0);
         chk("rst_d_valid", h_o[i].d_valid, 0);
      end
      @(posedge clk);
      #1 rst_ni = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < M; i++) begin
         h_i[i].a_valid = 1'b0;
         h_i[i].d_ready = 1'b1;
      end
      for (int n = 0; n < 2 * MAXO && m_q.size() > 0; n++) begin
         d_i.d_valid = 1'b1;
         d_i.d_data  = $urandom;
         cyc();
      end
      d_i.d_valid = 1'b0;
   endtask

   initial begin
      idle_inputs();
      m_reset();

      // round-robin fairness, each response returned the next cycle
      do_reset();
      d_i.a_ready = 1'b1;
      for (int i = 0; i < M; i++) begin
         h_i[i].a_valid = 1'b1;
         h_i[i].d_ready = 1'b1;
      end
      for (int k = 0; k < 9; k++) begin
         for (int i = 0; i < M; i++) h_i[i].a_address = $urandom;
         d_i.d_valid = (m_q.size() > 0);
         d_i.d_data  = $urandom;
         cyc(k % M);
      end
      drain();

      // lock holds host 1 while device stalls; pointer then moves to 2
      do_reset();
      d_i.a_ready = 1'b1;
      h_i[0].a_valid = 1'b1;
      cyc(0);
      h_i[1].a_valid = 1'b1;
      h_i[1].a_address = 32'h1000_0010;
      d_i.a_ready = 1'b0;
      repeat (3) cyc(1);
      d_i.a_ready = 1'b1;
      cyc(1);
      h_i[1].a_valid = 1'b0;
      h_i[2].a_valid = 1'b1;
      cyc(2);
      h_i[2].a_valid = 1'b0;
      cyc(0);
      drain();

      // in-order response routing
      do_reset();
      d_i.a_ready = 1'b1;
      h_i[2].a_valid = 1'b1;
      cyc(2);
      h_i[2].a_valid = 1'b0;
      h_i[0].a_valid = 1'b1;
      cyc(0);
      h_i[0].a_valid = 1'b0;
      for (int i = 0; i < M; i++) h_i[i].d_ready = 1'b1;
      d_i.d_valid = 1'b1;
      d_i.d_data  = 32'hA5A5_A5A5;
      #2;
      chk("route_h2_data", h_o[2].d_data, 32'hA5A5_A5A5);
      chk("route_h2_valid", h_o[2].d_valid, 1);
      chk("route_h0_quiet", h_o[0].d_valid, 0);
      cyc();
      d_i.d_data = 32'h5A5A_5A5A;
      #2;
      chk("route_h0_data", h_o[0].d_data, 32'h5A5A_5A5A);
      chk("route_h0_valid", h_o[0].d_valid, 1);
      chk("route_h2_quiet", h_o[2].d_valid, 0);
      cyc();
      d_i.d_valid = 1'b0;
      cyc();

      // FIFO full backpressure and one-cycle recovery
      do_reset();
      d_i.a_ready = 1'b1;
      h_i[1].a_valid = 1'b1;
      h_i[1].d_ready = 1'b1;
      repeat (MAXO) cyc(1);
      #2;
      chk("full_count", outstanding, MAXO);
      chk("full_a_ready", h_o[1].a_ready, 0);
      cyc();
      d_i.d_valid = 1'b1;
      #2;
      chk("full_pop_a_ready", h_o[1].a_ready, 0);
      cyc();
      d_i.d_valid = 1'b0;
      #2;
      chk("recover_a_ready", h_o[1].a_ready, 1);
      chk("recover_count", outstanding, MAXO - 1);
      cyc(1);
      #2;
      chk("refill_count", outstanding, MAXO);
      drain();

      // randomized traffic
      do_reset();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < M; i++) begin
            if (!(m_lock != 0 && m_lhost == i)) begin
               h_i[i].a_valid   = $urandom_range(0, 1);
               h_i[i].a_address = $urandom;
               h_i[i].a_data    = $urandom;
            end
            h_i[i].d_ready = ($urandom_range(0, 3) != 0);
         end
         d_i.a_ready = ($urandom_range(0, 3) != 0);
         d_i.d_valid = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
         d_i.d_data  = $urandom;
         cyc();
      end
      drain();

      // spurious response with an empty FIFO
      do_reset();
      d_i.d_valid = 1'b1;
      #2;
      chk("spur_d_ready", d_o.d_ready, 1);
      cyc();
      d_i.d_valid = 1'b0;
      #2;
      chk("spur_sticky", err_sp, 1);
      repeat (3) cyc();

      // asynchronous reset mid-burst
      do_reset();
      d_i.a_ready = 1'b1;
      for (int i = 0; i < M; i++) begin
         h_i[i].a_valid = 1'b1;
         h_i[i].d_ready = 1'b1;
      end
      for (int k = 0; k < 3; k++) cyc(k);
      d_i.d_valid = 1'b1;
      #1;
      chk("pre_rst_count", outstanding, 3);
      #1 rst_ni = 1'b0;
      #1;
      chk("async_rst_count", outstanding, 0);
      for (int i = 0; i < M; i++) begin
         chk("async_rst_a_ready", h_o[i].a_ready, 0);
         chk("async_rst_d_valid", h_o[i].d_valid, 0);
      end
      idle_inputs();
      m_reset();
      @(posedge clk);
      #1 rst_ni = 1'b1;
      d_i.a_ready = 1'b1;
      for (int i = 0; i < M; i++) h_i[i].a_valid = 1'b1;
      cyc(0);
      cyc(1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
